qk_tile_buffer: RTL and testbench
=================================

QK_TILE_BUFFER -- requirements
Module: qk_tile_buffer

Interface
REQ-001 Parameter DIM, default 16: the QK score matrix is DIM x DIM entries.
REQ-002 Parameter ADDR_W, default 4: width of each matrix coordinate; DIM = 2**ADDR_W.
REQ-003 Parameter DATA_W, default 8: width of one score entry.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 wr_valid  input  1  host write beat valid.
REQ-007 wr_ready  output  1  buffer can accept a write beat.
REQ-008 wr_data  input  DATA_W  score entry, delivered in raster order (row 0 col 0 first, column fastest).
REQ-009 wr_last  input  1  host marks the final beat of a tile.
REQ-010 data_req  input  1  SASA controller read strobe.
REQ-011 data_addr_x  input  ADDR_W  column coordinate of the read.
REQ-012 data_addr_y  input  ADDR_W  row coordinate of the read.
REQ-013 data  output  DATA_W  read data.
REQ-014 tile_valid  output  1  the read bank holds a complete tile.
REQ-015 tile_release  input  1  one-cycle pulse from the controller (its finish) that frees the read bank.
REQ-016 bank_full  output  2  per-bank full flags; bit i is bank i.
REQ-017 rd_count  output  ADDR_W*2+1  number of accepted reads from the current read bank.
REQ-018 err_wr  output  1  sticky write-framing error.
REQ-019 err_rd  output  1  sticky read-while-empty error.

Function
REQ-020 The block SHALL hold two banks of DIM*DIM entries, used ping-pong; the load pointer lb selects the write bank and the read pointer rb selects the read bank.
REQ-021 wr_ready SHALL equal NOT bank_full[lb].
REQ-022 A write beat is accepted when wr_valid and wr_ready are both high; it stores wr_data at bank[lb][wr_idx] and increments wr_idx (0 to DIM*DIM-1).
REQ-023 On the accepted beat with wr_idx = DIM*DIM-1, the block SHALL set bank_full[lb], clear wr_idx to 0, and toggle lb, all on the same edge.
REQ-024 If wr_last on an accepted beat disagrees with wr_idx = DIM*DIM-1 (high early or low on the final beat), err_wr SHALL be set; the tile still completes on the DIM*DIM-th beat only.
REQ-025 tile_valid SHALL equal bank_full[rb].
REQ-026 data SHALL be combinational, equal to bank[rb][data_addr_y*DIM + data_addr_x] when data_req and tile_valid are both high, and 0 otherwise (zero-latency, sampled by the consumer in the same cycle).
REQ-027 Each cycle with data_req and tile_valid high SHALL increment rd_count, saturating at 2**(2*ADDR_W+1)-1.
REQ-028 data_req while tile_valid is low SHALL set err_rd and return data = 0, with rd_count unchanged.
REQ-029 tile_release while tile_valid is high SHALL clear bank_full[rb], toggle rb, and clear rd_count to 0 on the next edge.
REQ-030 tile_release while tile_valid is low SHALL be ignored.
REQ-031 On the edge where tile_release and the final write beat both occur:
- both updates SHALL apply.
- If both target the same bank (lb = rb, with that bank empty), the write completes first: bank_full is set, and the release is ignored because tile_valid was low.
REQ-032 When both banks are full, wr_ready SHALL be low and wr_data SHALL be ignored until a release occurs.
REQ-033 A data_req and tile_release in the same cycle: the read returns the old bank's data and is counted before the rd_count clear (the clear wins).
REQ-034 Address arithmetic SHALL be unsigned, ADDR_W*2 bits, with no out-of-range case, since DIM = 2**ADDR_W.

Reset
REQ-035 While reset is low, asynchronously:
- lb = rb = 0, wr_idx = 0, bank_full = 2'b00, rd_count = 0, err_wr = err_rd = 0.
- Consequently wr_ready = 1, tile_valid = 0, data = 0.
REQ-036 Bank contents SHALL NOT be required to reset; they are unreadable until refilled.
REQ-037 Reset asserted mid-load SHALL discard the partial tile; the next beat after release is written at index 0 of bank 0.
REQ-038 err_wr and err_rd SHALL clear only on reset.

Verification
REQ-039 Write 256 beats (value = index mod 256, wr_last on beat 255) -> bank_full=01, tile_valid=1; read (x=3,y=2) -> data=35, rd_count=1.
REQ-040 Load two tiles with no release -> bank_full=11, wr_ready=0; 10 further wr_valid cycles are ignored; tile_release -> bank_full=10, rb=1, rd_count=0, wr_ready=1.
REQ-041 data_req after reset with no tile loaded -> data=0, err_rd=1, rd_count=0.
REQ-042 wr_last asserted on beat 100 -> err_wr=1, tile_valid stays 0 until beat 255 is accepted.
REQ-043 Release and the final write beat in the same cycle, with bank 0 full and bank 1 loading -> bank_full=10, rb=1, lb=0, tile_valid=1 next cycle.
REQ-044 Reset pulse after 50 accepted beats -> all outputs at their reset values immediately; the next 256 beats complete tile 0 correctly.

Source files
------------

// File: rtl/qk_tile_buffer.sv
// Ping-pong QK score tile buffer: the host streams raster-order tiles in and the SASA controller reads them.
// Reads are zero-latency combinational. Writes stall with wr_ready low while the load bank is still full.
module qk_tile_buffer #(
    parameter int DIM    = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_last,
    input  logic                  data_req,
    input  logic [ADDR_W-1:0]     data_addr_x,
    input  logic [ADDR_W-1:0]     data_addr_y,
    output logic [DATA_W-1:0]     data,
    output logic                  tile_valid,
    input  logic                  tile_release,
    output logic [1:0]            bank_full,
    output logic [ADDR_W*2:0]     rd_count,
    output logic                  err_wr,
    output logic                  err_rd
);

    localparam int IDX_W = 2 * ADDR_W;
    localparam int CNT_W = 2 * ADDR_W + 1;
    localparam int DEPTH = DIM * DIM;
    localparam logic [IDX_W-1:0] IDX_LAST = '1;
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [2][DEPTH];

    logic             lb_q, lb_d;
    logic             rb_q, rb_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [1:0]       bank_full_q, bank_full_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic             err_wr_q, err_wr_d;
    logic             err_rd_q, err_rd_d;

    logic             wr_acc;
    logic             wr_final;
    logic             rd_acc;
    logic             rel_acc;
    logic [IDX_W-1:0] rd_addr;

    assign wr_ready   = ~bank_full_q[lb_q];
    assign tile_valid = bank_full_q[rb_q];
    assign wr_acc     = wr_valid & wr_ready;
    assign wr_final   = wr_acc & (wr_idx_q == IDX_LAST);
    assign rd_acc     = data_req & tile_valid;
    assign rel_acc    = tile_release & tile_valid;
    // DIM is a power of two, so row*DIM + col is just the concatenation.
    assign rd_addr    = {data_addr_y, data_addr_x};

    assign data      = rd_acc ? mem_q[rb_q][rd_addr] : '0;
    assign bank_full = bank_full_q;
    assign rd_count  = rd_count_q;
    assign err_wr    = err_wr_q;
    assign err_rd    = err_rd_q;

    always_comb begin
        lb_d        = lb_q;
        rb_d        = rb_q;
        wr_idx_d    = wr_idx_q;
        bank_full_d = bank_full_q;
        rd_count_d  = rd_count_q;
        err_wr_d    = err_wr_q;
        err_rd_d    = err_rd_q;

        if (wr_acc) begin
            wr_idx_d = wr_idx_q + IDX_ONE;
            if (wr_last != (wr_idx_q == IDX_LAST)) begin
                err_wr_d = 1'b1;
            end
        end

        if (rd_acc && (rd_count_q != CNT_MAX)) begin
            rd_count_d = rd_count_q + CNT_ONE;
        end

        if (data_req && !tile_valid) begin
            err_rd_d = 1'b1;
        end

        // Release only fires on a full read bank; a write can only complete on an
        // empty load bank, so when lb == rb the two never touch the same flag.
        if (rel_acc) begin
            bank_full_d[rb_q] = 1'b0;
            rb_d              = ~rb_q;
            rd_count_d        = '0;
        end

        if (wr_final) begin
            bank_full_d[lb_q] = 1'b1;
            lb_d              = ~lb_q;
            wr_idx_d          = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wr_idx_q    <= '0;
            bank_full_q <= 2'b00;
            rd_count_q  <= '0;
            err_wr_q    <= 1'b0;
            err_rd_q    <= 1'b0;
        end else begin
            lb_q        <= lb_d;
            rb_q        <= rb_d;
            wr_idx_q    <= wr_idx_d;
            bank_full_q <= bank_full_d;
            rd_count_q  <= rd_count_d;
            err_wr_q    <= err_wr_d;
            err_rd_q    <= err_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[lb_q][wr_idx_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_qk_tile_buffer.sv
module tb_qk_tile_buffer;

    logic       clk;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       data_req;
    logic [3:0] data_addr_x;
    logic [3:0] data_addr_y;
    logic [7:0] data;
    logic       tile_valid;
    logic       tile_release;
    logic [1:0] bank_full;
    logic [8:0] rd_count;
    logic       err_wr;
    logic       err_rd;

    int n_checks = 0;
    int n_pass   = 0;

    qk_tile_buffer #(.DIM(16), .ADDR_W(4), .DATA_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .data_req     (data_req),
        .data_addr_x  (data_addr_x),
        .data_addr_y  (data_addr_y),
        .data         (data),
        .tile_valid   (tile_valid),
        .tile_release (tile_release),
        .bank_full    (bank_full),
        .rd_count     (rd_count),
        .err_wr       (err_wr),
        .err_rd       (err_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset        = 1'b0;
        wr_valid     = 1'b0;
        wr_data      = 8'h00;
        wr_last      = 1'b0;
        data_req     = 1'b0;
        data_addr_x  = 4'd0;
        data_addr_y  = 4'd0;
        tile_release = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // pat 0 writes value idx, pat 1 writes 255-idx; wr_last goes high on beat last_at.
    task automatic write_beats(input int n, input int first, input bit pat, input int last_at,
                               input bit rel_last);
        for (int i = 0; i < n; i++) begin
            int idx;
            idx          = first + i;
            wr_valid     = 1'b1;
            wr_data      = pat ? 8'(255 - idx) : 8'(idx);
            wr_last      = (idx == last_at);
            tile_release = rel_last && (i == n - 1);
            @(posedge clk);
            #1;
        end
        wr_valid     = 1'b0;
        wr_last      = 1'b0;
        tile_release = 1'b0;
    endtask

    task automatic read_at(input int x, input int y, output logic [7:0] got);
        data_addr_x = 4'(x);
        data_addr_y = 4'(y);
        data_req    = 1'b1;
        #1;
        got = data;
        @(posedge clk);
        #1;
        data_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); else n_pass++;
        n_checks++; if (tile_valid !== 1'b0) $display("FAIL reset_tile_valid got=%b exp=0", tile_valid); else n_pass++;
        n_checks++; if (bank_full !== 2'b00) $display("FAIL reset_bank_full got=%b exp=00", bank_full); else n_pass++;
        n_checks++; if (rd_count !== 9'd0) $display("FAIL reset_rd_count got=%0d exp=0", rd_count); else n_pass++;
        n_checks++; if (data !== 8'd0) $display("FAIL reset_data got=%0d exp=0", data); else n_pass++;
        n_checks++; if ({err_wr, err_rd} !== 2'b00) $display("FAIL reset_errs got=%b exp=00", {err_wr, err_rd}); else n_pass++;
    endtask

    task automatic test_read_empty();
        logic [7:0] got;
        read_at(3, 2, got);
        n_checks++; if (got !== 8'd0) $display("FAIL empty_read_data got=%0d exp=0", got); else n_pass++;
        n_checks++; if (err_rd !== 1'b1) $display("FAIL empty_read_err_rd got=%b exp=1", err_rd); else n_pass++;
        n_checks++; if (rd_count !== 9'd0) $display("FAIL empty_read_rd_count got=%0d exp=0", rd_count); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (err_rd !== 1'b1) $display("FAIL err_rd_sticky got=%b exp=1", err_rd); else n_pass++;
    endtask

    task automatic test_fill_and_read();
        logic [7:0] got;
        do_reset();
        write_beats(256, 0, 1'b0, 255, 1'b0);
        n_checks++; if (bank_full !== 2'b01) $display("FAIL fill_bank_full got=%b exp=01", bank_full); else n_pass++;
        n_checks++; if (tile_valid !== 1'b1) $display("FAIL fill_tile_valid got=%b exp=1", tile_valid); else n_pass++;
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL fill_wr_ready got=%b exp=1", wr_ready); else n_pass++;
        n_checks++; if (err_wr !== 1'b0) $display("FAIL fill_err_wr got=%b exp=0", err_wr); else n_pass++;
        read_at(3, 2, got);
        n_checks++; if (got !== 8'd35) $display("FAIL read_3_2 got=%0d exp=35", got); else n_pass++;
        n_checks++; if (rd_count !== 9'd1) $display("FAIL read_count_1 got=%0d exp=1", rd_count); else n_pass++;
        read_at(15, 15, got);
        n_checks++; if (got !== 8'd255) $display("FAIL read_15_15 got=%0d exp=255", got); else n_pass++;
        read_at(0, 0, got);
        n_checks++; if (got !== 8'd0) $display("FAIL read_0_0 got=%0d exp=0", got); else n_pass++;
        read_at(7, 1, got);
        n_checks++; if (got !== 8'd23) $display("FAIL read_7_1 got=%0d exp=23", got); else n_pass++;
        n_checks++; if (rd_count !== 9'd4) $display("FAIL read_count_4 got=%0d exp=4", rd_count); else n_pass++;
    endtask

    task automatic test_both_full();
        logic [7:0] got;
        write_beats(256, 0, 1'b1, 255, 1'b0);
        n_checks++; if (bank_full !== 2'b11) $display("FAIL full_bank_full got=%b exp=11", bank_full); else n_pass++;
        n_checks++; if (wr_ready !== 1'b0) $display("FAIL full_wr_ready got=%b exp=0", wr_ready); else n_pass++;
        wr_valid = 1'b1;
        wr_data  = 8'hAA;
        wr_last  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        n_checks++; if (bank_full !== 2'b11) $display("FAIL stalled_bank_full got=%b exp=11", bank_full); else n_pass++;
        n_checks++; if (err_wr !== 1'b0) $display("FAIL stalled_err_wr got=%b exp=0", err_wr); else n_pass++;
        // Read and release in the same cycle: old bank data returned, count cleared.
        data_addr_x  = 4'd3;
        data_addr_y  = 4'd2;
        data_req     = 1'b1;
        tile_release = 1'b1;
        #1;
        n_checks++; if (data !== 8'd35) $display("FAIL rel_read_data got=%0d exp=35", data); else n_pass++;
        @(posedge clk);
        #1;
        data_req     = 1'b0;
        tile_release = 1'b0;
        n_checks++; if (bank_full !== 2'b10) $display("FAIL rel_bank_full got=%b exp=10", bank_full); else n_pass++;
        n_checks++; if (rd_count !== 9'd0) $display("FAIL rel_rd_count got=%0d exp=0", rd_count); else n_pass++;
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL rel_wr_ready got=%b exp=1", wr_ready); else n_pass++;
        n_checks++; if (tile_valid !== 1'b1) $display("FAIL rel_tile_valid got=%b exp=1", tile_valid); else n_pass++;
        read_at(3, 2, got);
        n_checks++; if (got !== 8'd220) $display("FAIL bank1_read_3_2 got=%0d exp=220", got); else n_pass++;
        read_at(0, 0, got);
        n_checks++; if (got !== 8'd255) $display("FAIL bank1_read_0_0 got=%0d exp=255", got); else n_pass++;
        n_checks++; if (rd_count !== 9'd2) $display("FAIL bank1_rd_count got=%0d exp=2", rd_count); else n_pass++;
    endtask

    task automatic test_release_with_final();
        logic [7:0] got;
        do_reset();
        tile_release = 1'b1;
        @(posedge clk);
        #1;
        tile_release = 1'b0;
        n_checks++; if (bank_full !== 2'b00) $display("FAIL idle_release_bank_full got=%b exp=00", bank_full); else n_pass++;
        // Same-bank case: release on an empty read bank is dropped, the write completes.
        write_beats(256, 0, 1'b0, 255, 1'b1);
        n_checks++; if (bank_full !== 2'b01) $display("FAIL same_bank_bank_full got=%b exp=01", bank_full); else n_pass++;
        write_beats(256, 0, 1'b1, 255, 1'b1);
        n_checks++; if (bank_full !== 2'b10) $display("FAIL cross_bank_full got=%b exp=10", bank_full); else n_pass++;
        n_checks++; if (tile_valid !== 1'b1) $display("FAIL cross_tile_valid got=%b exp=1", tile_valid); else n_pass++;
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL cross_wr_ready got=%b exp=1", wr_ready); else n_pass++;
        read_at(3, 2, got);
        n_checks++; if (got !== 8'd220) $display("FAIL cross_read_3_2 got=%0d exp=220", got); else n_pass++;
    endtask

    task automatic test_wr_last_early();
        do_reset();
        write_beats(101, 0, 1'b0, 100, 1'b0);
        n_checks++; if (err_wr !== 1'b1) $display("FAIL early_last_err_wr got=%b exp=1", err_wr); else n_pass++;
        n_checks++; if (tile_valid !== 1'b0) $display("FAIL early_last_tile_valid got=%b exp=0", tile_valid); else n_pass++;
        write_beats(154, 101, 1'b0, 100, 1'b0);
        n_checks++; if (tile_valid !== 1'b0) $display("FAIL beat254_tile_valid got=%b exp=0", tile_valid); else n_pass++;
        write_beats(1, 255, 1'b0, 100, 1'b0);
        n_checks++; if (tile_valid !== 1'b1) $display("FAIL beat255_tile_valid got=%b exp=1", tile_valid); else n_pass++;
        n_checks++; if (err_wr !== 1'b1) $display("FAIL err_wr_sticky got=%b exp=1", err_wr); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] got;
        do_reset();
        write_beats(50, 0, 1'b1, 999, 1'b0);
        read_at(0, 0, got);
        n_checks++; if (err_rd !== 1'b1) $display("FAIL pre_reset_err_rd got=%b exp=1", err_rd); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if ({wr_ready, tile_valid, bank_full} !== 4'b1000) $display("FAIL async_reset_flags got=%b exp=1000", {wr_ready, tile_valid, bank_full}); else n_pass++;
        n_checks++; if ({err_wr, err_rd} !== 2'b00) $display("FAIL async_reset_errs got=%b exp=00", {err_wr, err_rd}); else n_pass++;
        n_checks++; if (rd_count !== 9'd0) $display("FAIL async_reset_rd_count got=%0d exp=0", rd_count); else n_pass++;
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        write_beats(256, 0, 1'b0, 255, 1'b0);
        n_checks++; if (bank_full !== 2'b01) $display("FAIL reload_bank_full got=%b exp=01", bank_full); else n_pass++;
        n_checks++; if (err_wr !== 1'b0) $display("FAIL reload_err_wr got=%b exp=0", err_wr); else n_pass++;
        read_at(3, 2, got);
        n_checks++; if (got !== 8'd35) $display("FAIL reload_read_3_2 got=%0d exp=35", got); else n_pass++;
        read_at(1, 0, got);
        n_checks++; if (got !== 8'd1) $display("FAIL reload_read_1_0 got=%0d exp=1", got); else n_pass++;
    endtask

    task automatic test_rd_saturate();
        data_addr_x = 4'd5;
        data_addr_y = 4'd5;
        data_req    = 1'b1;
        repeat (515) @(posedge clk);
        #1;
        n_checks++; if (data !== 8'd85) $display("FAIL sat_read_5_5 got=%0d exp=85", data); else n_pass++;
        data_req = 1'b0;
        n_checks++; if (rd_count !== 9'd511) $display("FAIL rd_count_saturate got=%0d exp=511", rd_count); else n_pass++;
        tile_release = 1'b1;
        @(posedge clk);
        #1;
        tile_release = 1'b0;
        n_checks++; if (rd_count !== 9'd0) $display("FAIL sat_release_rd_count got=%0d exp=0", rd_count); else n_pass++;
        n_checks++; if (tile_valid !== 1'b0) $display("FAIL sat_release_tile_valid got=%b exp=0", tile_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read_empty();
        test_fill_and_read();
        test_both_full();
        test_release_with_final();
        test_wr_last_early();
        test_reset_mid_load();
        test_rd_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
